seq_fsm_param: RTL and testbench
================================

SEQ_FSM_PARAM -- requirements
Module: seq_fsm_param

Interface
REQ-001 The block SHALL have parameter TO_CYCLES, default 16, giving the maximum number of cycles spent in WAIT (legal >= 1).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 2, giving the minimum number of cycles spent in DONE (legal >= 1).
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the width of the completed-transaction counter (legal >= 1).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset; asynchronous, active-low.
REQ-006 en  input  1  enable; low aborts any transaction and holds the FSM in IDLE.
REQ-007 sig1  input  1  start request A.
REQ-008 sig2  input  1  start request B; also one of the two completion qualifiers.
REQ-009 sig3  input  1  completion qualifier, and the DONE release.
REQ-010 clr_cnt  input  1  synchronous clear of done_cnt.
REQ-011 q_sig4  output  1  registered; high exactly while state is DONE.
REQ-012 tout_o  output  1  registered; one-cycle pulse while state is TOUT.
REQ-013 state_o  output  2  current state: IDLE=00, WAIT=01, DONE=10, TOUT=11.
REQ-014 done_cnt  output  CNT_W  count of completed transactions; saturating.

Function
REQ-015 The block SHALL be a three-process FSM:
- a state register;
- combinational next-state logic;
- output registers loaded from the decoded next state.
REQ-016 IDLE SHALL go to WAIT when en=1 and (sig1 or sig2) is true, and SHALL otherwise stay in IDLE.
REQ-017 The WAIT timer SHALL be cleared on entry to WAIT and SHALL increment once per cycle spent in WAIT.
- Timer width SHALL be $clog2(TO_CYCLES+1).
REQ-018 WAIT SHALL go to DONE when sig2 and sig3 are both 1.
REQ-019 If the REQ-018 condition is false and the timer equals TO_CYCLES-1, WAIT SHALL go to TOUT.
- Otherwise the FSM SHALL stay in WAIT.
- WAIT therefore lasts at most TO_CYCLES cycles.
REQ-020 When completion and timeout coincide in the same cycle, completion SHALL win: next state DONE, no tout_o pulse.
REQ-021 The hold counter SHALL be cleared on entry to DONE and SHALL increment once per cycle spent in DONE.
REQ-022 DONE SHALL go to IDLE when sig3=1 and the hold counter is >= HOLD_CYCLES-1, and SHALL otherwise stay in DONE.
REQ-023 TOUT SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-024 en=0 in any state SHALL force the next state to IDLE.
- This overrides all other transitions.
- It SHALL NOT increment done_cnt or pulse tout_o.
REQ-025 q_sig4 SHALL be registered as (next_state==DONE), so it rises on the same edge that state_o becomes 10; there is no extra latency.
REQ-026 tout_o SHALL be registered as (next_state==TOUT).
REQ-027 done_cnt SHALL increment by 1 on each DONE->IDLE transition taken via REQ-022.
- It SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 clr_cnt=1 SHALL set done_cnt to 0 on the next edge, and SHALL take priority over a simultaneous increment.
REQ-029 An illegal state encoding cannot occur with 2 bits and 4 used codes; the default branch SHALL nonetheless go to IDLE with q_sig4=0.

Reset
REQ-030 reset_n=0 SHALL immediately, without waiting for a clock edge, set:
- state_o=00;
- q_sig4=0, tout_o=0;
- done_cnt=0;
- WAIT timer and hold counter to 0.
REQ-031 After reset_n rises, the first state change SHALL occur no earlier than the next rising edge of clk.
REQ-032 Assertion of reset_n=0 mid-transaction, in any state, SHALL abort the transaction without incrementing done_cnt.

Verification
REQ-033 Reset: drive reset_n=0 for 3 cycles with random inputs -> state_o=00, q_sig4=0, tout_o=0, done_cnt=0 throughout.
REQ-034 Normal flow (defaults, en=1): sig1=1 before edge 1, then sig2=sig3=1 held from before edge 3 ->
- state_o=01 after edge 1;
- state_o=10 and q_sig4=1 after edge 3;
- state_o=00 and q_sig4=0 after edge 5;
- done_cnt=1.
REQ-035 Timeout: enter WAIT, keep sig3=0 -> 16 cycles in WAIT, then state_o=11 with tout_o=1 for exactly 1 cycle, then state_o=00; done_cnt unchanged.
REQ-036 Coincidence: assert sig2=sig3=1 only in the 16th WAIT cycle -> state_o=10 next, tout_o never 1.
REQ-037 Saturation/clear, with CNT_W=2: 4 completed transactions -> done_cnt=3, holding at 3; then clr_cnt=1 on the 5th DONE exit edge -> done_cnt=0.
REQ-038 Abort:
- en=0 while in DONE -> state_o=00 and q_sig4=0 next edge, done_cnt unchanged;
- reset_n=0 mid-WAIT -> all outputs 0 with no clock edge required.

Source files
------------

// File: rtl/seq_fsm_param.sv
// Start/complete handshake FSM with a WAIT timeout, a minimum DONE hold
// and a saturating count of completed transactions.
module seq_fsm_param #(
    parameter int TO_CYCLES   = 16,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sig1,
    input  logic             sig2,
    input  logic             sig3,
    input  logic             clr_cnt,
    output logic             q_sig4,
    output logic             tout_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int TW = $clog2(TO_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [TW-1:0]    TMAX = TW'(TO_CYCLES - 1);
    localparam logic [HW-1:0]    HMIN = HW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10,
        TOUT = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_sig4_q, q_sig4_d;
    logic             tout_q, tout_d;
    logic             done_hit;

    always_comb begin
        state_d  = state_q;
        done_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (sig1 || sig2) state_d = WAIT;
            end
            WAIT: begin
                // Completion is tested first so it wins over a timeout.
                if (sig2 && sig3)         state_d = DONE;
                else if (timer_q == TMAX) state_d = TOUT;
            end
            DONE: begin
                if (sig3 && (hold_q >= HMIN)) begin
                    state_d  = IDLE;
                    done_hit = 1'b1;
                end
            end
            TOUT: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (!en) begin
            state_d  = IDLE;
            done_hit = 1'b0;
        end

        timer_d = '0;
        if (state_q == WAIT && state_d == WAIT) timer_d = timer_q + TW'(1);

        // Hold count stops at its threshold so a long DONE cannot wrap it.
        hold_d = '0;
        if (state_q == DONE && state_d == DONE) begin
            hold_d = (hold_q >= HMIN) ? hold_q : hold_q + HW'(1);
        end

        cnt_d = cnt_q;
        if (clr_cnt)                        cnt_d = '0;
        else if (done_hit && cnt_q != CMAX) cnt_d = cnt_q + CNT_W'(1);

        q_sig4_d = (state_d == DONE);
        tout_d   = (state_d == TOUT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_sig4_q <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            q_sig4_q <= q_sig4_d;
            tout_q   <= tout_d;
        end
    end

    assign state_o  = state_q;
    assign q_sig4   = q_sig4_q;
    assign tout_o   = tout_q;
    assign done_cnt = cnt_q;

endmodule

// File: tb/tb_seq_fsm_param.sv
// Directed vector bench for seq_fsm_param (CNT_W=2, other params default).
module tb_seq_fsm_param;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       sig1 = 1'b0;
    logic       sig2 = 1'b0;
    logic       sig3 = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       q_sig4;
    logic       tout_o;
    logic [1:0] state_o;
    logic [1:0] done_cnt;

    int n_vec = 0;
    int n_bad = 0;

    seq_fsm_param #(.TO_CYCLES(16), .HOLD_CYCLES(2), .CNT_W(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .sig1     (sig1),
        .sig2     (sig2),
        .sig3     (sig3),
        .clr_cnt  (clr_cnt),
        .q_sig4   (q_sig4),
        .tout_o   (tout_o),
        .state_o  (state_o),
        .done_cnt (done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, s1, s2, s3, clr;
        logic [1:0] st;
        logic       q4, to;
        logic [1:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic e, logic a, logic b, logic c,
                                logic k, logic [1:0] st, logic q4,
                                logic to, logic [1:0] cnt);
        vec_t v;
        v.en = e; v.s1 = a; v.s2 = b; v.s3 = c; v.clr = k;
        v.st = st; v.q4 = q4; v.to = to; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    task automatic check(string name, logic [1:0] st, logic q4,
                         logic to, logic [1:0] cnt);
        n_vec++;
        if (state_o !== st || q_sig4 !== q4 || tout_o !== to ||
            done_cnt !== cnt) begin
            n_bad++;
            $display("FAIL %s: got st=%b q4=%b to=%b cnt=%0d, want st=%b q4=%b to=%b cnt=%0d",
                     name, state_o, q_sig4, tout_o, done_cnt,
                     st, q4, to, cnt);
        end
    endtask

    task automatic drive(logic e, logic a, logic b, logic c, logic k);
        en = e; sig1 = a; sig2 = b; sig3 = c; clr_cnt = k;
    endtask

    // Full transaction: start, complete, one hold cycle, release.
    task automatic txn_rows(logic [1:0] c0, logic [1:0] c1, logic k);
        add(1, 1, 0, 0, 0, 2'b01, 0, 0, c0);
        add(1, 0, 1, 1, 0, 2'b10, 1, 0, c0);
        add(1, 0, 0, 1, 0, 2'b10, 1, 0, c0);
        add(1, 0, 0, 1, k, 2'b00, 0, 0, c1);
    endtask

    initial begin
        // Normal flow
        add(1, 1, 0, 0, 0, 2'b01, 0, 0, 0);
        add(1, 0, 0, 0, 0, 2'b01, 0, 0, 0);
        add(1, 0, 1, 1, 0, 2'b10, 1, 0, 0);
        add(1, 0, 1, 1, 0, 2'b10, 1, 0, 0);
        add(1, 0, 1, 1, 0, 2'b00, 0, 0, 1);
        add(1, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        // Timeout: 16 WAIT cycles, one TOUT cycle
        add(1, 1, 0, 0, 0, 2'b01, 0, 0, 1);
        for (int i = 0; i < 15; i++) add(1, 0, i[0], 0, 0, 2'b01, 0, 0, 1);
        add(1, 0, 1, 0, 0, 2'b11, 0, 1, 1);
        add(1, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        // Completion coinciding with the last WAIT cycle
        add(1, 0, 1, 0, 0, 2'b01, 0, 0, 1);
        for (int i = 0; i < 15; i++) add(1, 0, 0, 0, 0, 2'b01, 0, 0, 1);
        add(1, 0, 1, 1, 0, 2'b10, 1, 0, 1);
        add(1, 0, 0, 0, 0, 2'b10, 1, 0, 1);
        add(1, 0, 0, 0, 0, 2'b10, 1, 0, 1);
        add(1, 0, 0, 1, 0, 2'b00, 0, 0, 2);
        // Saturation then clear on an exit edge
        txn_rows(2, 3, 0);
        txn_rows(3, 3, 0);
        txn_rows(3, 0, 1);
        // Abort by en=0 in DONE and in WAIT
        txn_rows(0, 1, 0);
        add(1, 1, 0, 0, 0, 2'b01, 0, 0, 1);
        add(1, 0, 1, 1, 0, 2'b10, 1, 0, 1);
        add(0, 0, 0, 1, 0, 2'b00, 0, 0, 1);
        add(0, 1, 1, 1, 0, 2'b00, 0, 0, 1);
        add(1, 1, 0, 0, 0, 2'b01, 0, 0, 1);
        add(0, 0, 1, 1, 0, 2'b00, 0, 0, 1);

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1));
            @(posedge clk); #1;
            check($sformatf("reset%0d", i), 2'b00, 0, 0, 0);
        end
        drive(0, 0, 0, 0, 0);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].s1, tbl[i].s2, tbl[i].s3, tbl[i].clr);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), tbl[i].st, tbl[i].q4,
                  tbl[i].to, tbl[i].cnt);
        end

        // Async reset mid-WAIT with a nonzero count
        drive(1, 1, 0, 0, 0);
        @(posedge clk); #1;
        check("pre_rst_wait", 2'b01, 0, 0, 1);
        drive(1, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1 check("async_rst_wait", 2'b00, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        @(posedge clk); #1;
        check("rst_held", 2'b00, 0, 0, 0);
        reset_n = 1'b1;
        #2 check("rst_release", 2'b00, 0, 0, 0);
        @(posedge clk); #1;
        check("first_edge", 2'b01, 0, 0, 0);

        // Async reset mid-DONE clears q_sig4 without an edge
        drive(1, 0, 1, 1, 0);
        @(posedge clk); #1;
        check("pre_rst_done", 2'b10, 1, 0, 0);
        #2 reset_n = 1'b0;
        #1 check("async_rst_done", 2'b00, 0, 0, 0);
        reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
